// File: rtl/ita_scm_fifo_ctrl.sv
// ita_scm_fifo_ctrl: valid/ready FIFO controller driving a 1W latch SCM as storage,
// hiding the 2-cycle write commit and 1-cycle read latency with a 1-entry prefetch.
module ita_scm_fifo_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  push_valid_i,
   output logic                  push_ready_o,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   output logic                  pop_valid_o,
   input  logic                  pop_ready_i,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  scm_we_o,
   output logic [ADDR_WIDTH-1:0] scm_waddr_o,
   output logic [DATA_WIDTH-1:0] scm_wdata_o,
   output logic                  scm_re_o,
   output logic [ADDR_WIDTH-1:0] scm_raddr_o,
   input  logic [DATA_WIDTH-1:0] scm_rdata_i
);
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   logic [ADDR_WIDTH:0] wr_ptr, cm_ptr, rd_ptr;
   logic cm_pend;
   logic clr, push_acc, pop_acc, fire;
   assign clr          = rst | flush_i;
   assign push_ready_o = !clr && count_o != FULL;
   assign push_acc     = push_valid_i & push_ready_o;
   assign pop_acc      = pop_valid_o & pop_ready_i;
   assign fire         = (cm_ptr != rd_ptr) && (!pop_valid_o || pop_ready_i) && !clr;
   assign scm_we_o     = push_acc;
   assign scm_waddr_o  = wr_ptr[ADDR_WIDTH-1:0];
   assign scm_wdata_o  = push_data_i;
   assign scm_re_o     = fire;
   assign scm_raddr_o  = rd_ptr[ADDR_WIDTH-1:0];
   assign pop_data_o   = scm_rdata_i;
   // Accept cycle is the first commit stage; cm_pend the second, so an entry becomes fetchable two cycles after push.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr      <= '0;
         cm_ptr      <= '0;
         rd_ptr      <= '0;
         cm_pend     <= 1'b0;
         pop_valid_o <= 1'b0;
         count_o     <= '0;
      end else begin
         wr_ptr      <= wr_ptr + (ADDR_WIDTH+1)'(push_acc);
         cm_pend     <= push_acc;
         cm_ptr      <= cm_ptr + (ADDR_WIDTH+1)'(cm_pend);
         rd_ptr      <= rd_ptr + (ADDR_WIDTH+1)'(fire);
         pop_valid_o <= fire | (pop_valid_o & !pop_ready_i);
         count_o     <= push_acc && !pop_acc ? count_o + 1'b1 :
                        !push_acc && pop_acc ? count_o - 1'b1 : count_o;
      end
   end
   a_count_max: assert property (@(posedge clk) disable iff (rst) count_o <= FULL);
   a_valid_nonempty: assert property (@(posedge clk) disable iff (rst) pop_valid_o |-> count_o != '0);
   a_head_stable: assert property (@(posedge clk) disable iff (clr)
      pop_valid_o && !pop_ready_i |=> $stable(pop_data_o));
endmodule
